program_loader: RTL
===================

// Module: program_loader
// PURPOSE
//  Boot-time loader that sits between the cpu core and system memory.
//  Holds the cpu in reset and writes a byte-stream program image (from UART/host) into memory.
//  Then releases the cpu and passes its address/data/read_write bus straight through to memory.
//  Re-entered on a reload pulse, so a new image can be loaded without a global reset.
// PARAMETERS
//  HOLD_CYCLES  4   cycles cpu_rst_n stays low after the last memory write (min 1)
// PORTS
//  clk             in   1   system clock, all logic on rising edge
//  rst             in   1   asynchronous active-low reset
//  in_valid        in   1   stream byte valid
//  in_data         in   8   stream byte
//  in_ready        out  1   loader accepts byte this cycle (transfer = in_valid & in_ready)
//  reload          in   1   1-cycle pulse: abort run, re-enter load
//  cpu_address     in   16  cpu address bus
//  cpu_data_write  in   8   cpu write data
//  cpu_read_write  in   1   cpu direction, 1=read 0=write
//  mem_address     out  16  memory address
//  mem_data_write  out  8   memory write data
//  mem_read_write  out  1   memory direction, 1=read 0=write
//  cpu_rst_n       out  1   active-low reset to cpu
//  busy            out  1   high in every state except S_RUN
//  error           out  1   sticky checksum failure (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=S_ADDRL, cpu_rst_n=0, busy=1, error=0, in_ready=0 on reset cycle then 1,
//   mem_address=0000, mem_data_write=00, mem_read_write=1, ptr=0000, len=0000.
//  Stream format, little-endian: ADDR_L ADDR_H LEN_L LEN_H then LEN payload bytes.
//  States: S_ADDRL->S_ADDRH->S_LENL->S_LENH: each advances on one transfer, latching the field.
//  S_LENH: on transfer, go to S_DATA if LEN!=0, else S_HOLD. LEN=0 means zero payload.
//  S_DATA: each transfer -> next cycle mem_address=ptr, mem_data_write=byte, mem_read_write=0
//   for exactly 1 cycle. Then ptr<=ptr+1 (16-bit wrap FFFF->0000), len<=len-1.
//   Transfers accepted back-to-back, one per cycle; gaps in in_valid only stall.
//   The transfer that makes len 0 moves to S_HOLD, after its write is issued.
//  S_HOLD: in_ready=0, counter runs HOLD_CYCLES cycles, then S_RUN.
//  S_RUN: cpu_rst_n=1, busy=0, in_ready=0. Memory outputs are a combinational pass-through of
//   the cpu_* inputs (zero latency, so cpu reads stay single-cycle).
//  Load states: mem_read_write=1 except write pulses. cpu_* inputs ignored. cpu_rst_n=0.
//  reload (any state): next state S_ADDRL, cpu_rst_n=0 from next cycle, in-flight write pulse
//   still completes, partial header/payload discarded, error cleared.
//  reload and a transfer in the same cycle: reload wins, byte dropped.
//  Async rst mid-load: immediate return to reset values. Memory contents are not restored.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined: one extra byte follows the payload (state S_CSUM, also taken
//   when LEN=0). Valid when 8-bit sum of payload + checksum byte == 00.
//   Pass -> S_HOLD. Fail -> S_ERR: error=1, cpu_rst_n=0, in_ready=0, leave only by reload/rst.
//  LOADER_CHECKSUM_EN undefined: no S_CSUM/S_ERR, no checksum byte, error tied to 0.
// TESTING
//  1 Stream 00 02 03 00 A9 05 EA -> writes 0200=A9, 0201=05, 0202=EA, one cycle each;
//    cpu_rst_n rises HOLD_CYCLES(4) cycles after the last write pulse; busy falls with it.
//  2 LEN=0000 (00 80 00 00) -> no write pulse, S_HOLD entered directly, cpu released.
//  3 Load at FFFF with LEN=2, bytes 11 22 -> FFFF=11, 0000=22 (pointer wrap).
//  4 S_RUN, cpu_address=1234 cpu_data_write=5A cpu_read_write=0 -> mem_* identical same cycle.
//  5 Pulse reload in S_RUN, then re-send test-1 stream with 01 02 03 -> cpu_rst_n low the next
//    cycle, 0200..0202=01,02,03, release repeats.
//  6 With LOADER_CHECKSUM_EN: payload 10 20, checksum D0 -> run.
//    Checksum D1 -> error=1, cpu_rst_n stays 0; then reload -> error=0.

Source files
------------

// File: rtl/program_loader.sv
// Boot loader: writes a little-endian ADDR/LEN/payload byte stream into memory while holding the cpu in reset,
// then releases it and passes the cpu bus straight through. Define LOADER_CHECKSUM_EN for a trailing checksum byte.
module program_loader #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        reload,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_data_write,
  input  logic        cpu_read_write,
  output logic [15:0] mem_address,
  output logic [7:0]  mem_data_write,
  output logic        mem_read_write,
  output logic        cpu_rst_n,
  output logic        busy,
  output logic        error
);

  typedef enum logic [3:0] {
    S_ADDRL,
    S_ADDRH,
    S_LENL,
    S_LENH,
    S_DATA,
    S_HOLD,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM,
    S_ERR,
`endif
    S_RUN
  } state_t;

  state_t      state_reg, state_next;
  logic        ready_en_reg;
  logic [15:0] ptr_reg;
  logic [15:0] len_reg;
  logic        wr_pulse_reg;
  logic [15:0] wr_addr_reg;
  logic [7:0]  wr_data_reg;
  logic [15:0] hold_cnt_reg;
  logic        xfer;
  logic        accept_state;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  sum_reg;
`endif

  always_comb begin
    accept_state = 1'b0;
    case (state_reg)
      S_ADDRL, S_ADDRH, S_LENL, S_LENH, S_DATA: accept_state = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CSUM:                                   accept_state = 1'b1;
`endif
      default:                                  accept_state = 1'b0;
    endcase
  end

  // ready_en_reg keeps in_ready low during the cycle right after reset
  assign in_ready = ready_en_reg & accept_state;
  // reload takes priority: a byte offered alongside it is dropped
  assign xfer     = in_valid & in_ready & ~reload;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_ADDRL;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (reload) begin
      state_next = S_ADDRL;
    end else begin
      case (state_reg)
        S_ADDRL: if (xfer) state_next = S_ADDRH;
        S_ADDRH: if (xfer) state_next = S_LENL;
        S_LENL:  if (xfer) state_next = S_LENH;
        S_LENH: begin
          if (xfer) begin
            if ({in_data, len_reg[7:0]} != 16'h0000) begin
              state_next = S_DATA;
            end else begin
`ifdef LOADER_CHECKSUM_EN
              state_next = S_CSUM;
`else
              state_next = S_HOLD;
`endif
            end
          end
        end
        S_DATA: begin
          if (xfer && len_reg == 16'h0001) begin
`ifdef LOADER_CHECKSUM_EN
            state_next = S_CSUM;
`else
            state_next = S_HOLD;
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (xfer) begin
            state_next = (8'(sum_reg + in_data) == 8'h00) ? S_HOLD : S_ERR;
          end
        end
        S_ERR: state_next = S_ERR;
`endif
        S_HOLD: if (hold_cnt_reg == 16'(HOLD_CYCLES - 1)) state_next = S_RUN;
        S_RUN:  state_next = S_RUN;
        default: state_next = S_ADDRL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_en_reg <= 1'b0;
      ptr_reg      <= 16'h0000;
      len_reg      <= 16'h0000;
      wr_pulse_reg <= 1'b0;
      wr_addr_reg  <= 16'h0000;
      wr_data_reg  <= 8'h00;
      hold_cnt_reg <= 16'h0000;
`ifdef LOADER_CHECKSUM_EN
      sum_reg      <= 8'h00;
`endif
    end else begin
      ready_en_reg <= 1'b1;
      wr_pulse_reg <= 1'b0;
      hold_cnt_reg <= (state_reg == S_HOLD) ? hold_cnt_reg + 16'h0001 : 16'h0000;
      if (xfer) begin
        case (state_reg)
          S_ADDRL: ptr_reg[7:0]  <= in_data;
          S_ADDRH: ptr_reg[15:8] <= in_data;
          S_LENL:  len_reg[7:0]  <= in_data;
          S_LENH: begin
            len_reg[15:8] <= in_data;
`ifdef LOADER_CHECKSUM_EN
            sum_reg       <= 8'h00;
`endif
          end
          S_DATA: begin
            wr_pulse_reg <= 1'b1;
            wr_addr_reg  <= ptr_reg;
            wr_data_reg  <= in_data;
            ptr_reg      <= ptr_reg + 16'h0001;
            len_reg      <= len_reg - 16'h0001;
`ifdef LOADER_CHECKSUM_EN
            sum_reg      <= sum_reg + in_data;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  assign busy      = (state_reg != S_RUN);
  assign cpu_rst_n = (state_reg == S_RUN);
`ifdef LOADER_CHECKSUM_EN
  assign error     = (state_reg == S_ERR);
`else
  assign error     = 1'b0;
`endif

  // Run mode is a pure combinational bypass so cpu accesses see no added latency
  always_comb begin
    if (state_reg == S_RUN) begin
      mem_address    = cpu_address;
      mem_data_write = cpu_data_write;
      mem_read_write = cpu_read_write;
    end else begin
      mem_address    = wr_addr_reg;
      mem_data_write = wr_data_reg;
      mem_read_write = ~wr_pulse_reg;
    end
  end

endmodule
